// File: rtl/decade_count_controller.sv
// decade_count_controller
// Command-driven sequencer for a chain of BCD decade digits. Counts qualified
// ticks in RUN, compares against a latched terminal count and pulses done.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is combinational from state and cmd_op. It is low during reset and
// low for a LOAD while in RUN, so a LOAD stalls instead of being dropped. The
// producer must hold cmd_op/cmd_data/term_count stable while cmd_valid is high
// and the command has not transferred.
module decade_count_controller #(
  parameter int DIGITS      = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4*DIGITS-1:0]   cmd_data,
  input  logic [4*DIGITS-1:0]   term_count,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic [DIGITS-1:0]     carry,
  output logic [1:0]            state,
  output logic                  done,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          state_q, state_n;
  logic [W-1:0]    tc_q, tc_n;
  logic [W-1:0]    count_n;
  logic [DIGITS-1:0] carry_n;
  logic            done_n;
  logic            err_n;

  logic [W-1:0]    inc_count;
  logic [DIGITS-1:0] inc_carry;
  logic [DIGITS-1:0] nines;
  logic            cin;
  logic            accept;

  // True when every nibble of v is a legal BCD digit.
  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign state     = state_q;
  assign cmd_ready = reset & ~((state_q == S_RUN) && (cmd_op == OP_LOAD));
  assign accept    = cmd_valid & cmd_ready;

  // Ripple BCD increment of the current count, plus a mask of digits at 9.
  always_comb begin
    cin       = 1'b1;
    inc_count = '0;
    inc_carry = '0;
    nines     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nines[i] = (count[4*i +: 4] == 4'd9);
      if (cin) begin
        if (nines[i]) begin
          inc_count[4*i +: 4] = 4'd0;
          inc_carry[i]        = 1'b1;
        end else begin
          inc_count[4*i +: 4] = count[4*i +: 4] + 4'd1;
          cin                 = 1'b0;
        end
      end else begin
        inc_count[4*i +: 4] = count[4*i +: 4];
      end
    end
  end

  // Next-state, next-count and event pulses for each state/command/tick mix.
  always_comb begin
    state_n = state_q;
    tc_n    = tc_q;
    count_n = count;
    carry_n = '0;
    done_n  = 1'b0;
    err_n   = err;
    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (accept) begin
          case (cmd_op)
            OP_START: begin
              if (state_q == S_PAUSE) begin
                state_n = S_RUN;
              end else if (is_bcd(term_count)) begin
                tc_n    = term_count;
                state_n = S_RUN;
              end else begin
                err_n = 1'b1;
              end
            end
            OP_LOAD: begin
              if (is_bcd(cmd_data)) count_n = cmd_data;
              else                  err_n   = 1'b1;
            end
            OP_CLEAR: begin
              count_n = '0;
              err_n   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // The tick is applied first; a STOP in the same cycle then pauses.
        if (tick) begin
          if (count == tc_q) begin
            count_n = '0;
            carry_n = nines;
            done_n  = 1'b1;
            if (AUTO_RELOAD == 0) state_n = S_DONE;
          end else begin
            count_n = inc_count;
            carry_n = inc_carry;
          end
        end
        if (accept) begin
          case (cmd_op)
            OP_CLEAR: begin
              // CLEAR overrides any tick in the same cycle.
              count_n = '0;
              carry_n = '0;
              done_n  = 1'b0;
              state_n = S_RUN;
            end
            OP_STOP: begin
              if (state_n != S_DONE) state_n = S_PAUSE;
            end
            default: ;
          endcase
        end
      end
      S_DONE: begin
        if (accept) begin
          case (cmd_op)
            OP_START: begin
              if (is_bcd(term_count)) begin
                tc_n    = term_count;
                state_n = S_RUN;
              end else begin
                err_n = 1'b1;
              end
            end
            OP_CLEAR: begin
              err_n   = 1'b0;
              state_n = S_IDLE;
            end
            OP_LOAD: begin
              if (is_bcd(cmd_data)) begin
                count_n = cmd_data;
                state_n = S_IDLE;
              end else begin
                err_n = 1'b1;
              end
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, terminal count and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tc_q    <= '0;
      count   <= '0;
      carry   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      tc_q    <= tc_n;
      count   <= count_n;
      carry   <= carry_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule
